if_fetch_stage: RTL

Instruction-fetch stage of cpu_pipelined, sitting between the PC/instruction memory and the IF/ID pipeline register. It owns the PC and drives the instruction-memory address. It holds and squashes fetches on hazard stall and branch flush. It detects the all-ones halt sentinel, drains the downstream pipeline, then raises end_program and freezes a cycle counter for the bench.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 32 +++
 rtl/if_fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Constants and types shared across the cpu_pipelined stages.
package cpu_pkg;
    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and bubble controls.
// Latency: one cycle from d to q.
// Backpressure: hold keeps q; bubble wins over hold and loads a NOP.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = cpu_pkg::NOP_WORD
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);
    if_id_t bubble_val;

    always_comb begin
        bubble_val          = '0;
        bubble_val.instr    = BUBBLE_INSTR;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= bubble_val;
        end else if (bubble) begin
            q <= bubble_val;
        end else if (!hold) begin
            q <= d;
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, fills IF/ID, drains and halts on sentinel.
// Latency: one cycle from imem_rdata to IF/ID.
// Backpressure: stall holds PC and IF/ID; flush redirects and squashes.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_DEPTH   = 64,
    parameter logic [31:0] HALT_WORD    = cpu_pkg::HALT_WORD,
    parameter logic [31:0] NOP_WORD     = cpu_pkg::NOP_WORD,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        end_program,
    output logic [31:0] cycle_count
);
    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);
    localparam logic [7:0]  DRAIN_INIT  = 8'(DRAIN_CYCLES);

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  target_aligned;
    logic [7:0]   drain_cnt;
    fetch_state_t state;
    logic         halt_hit;
    logic         ifid_hold;
    logic         ifid_bubble;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign pc_plus4       = pc + 32'd4;
    assign target_aligned = {branch_target[31:2], 2'b00};
    // Running off the end of memory is treated exactly like the sentinel.
    assign halt_hit       = (imem_rdata == HALT_WORD) || (pc[31:2] >= DEPTH_WORDS);
    assign imem_addr      = pc;

    always_comb begin
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b1;
        if (state == RUN) begin
            if (flush) begin
                ifid_bubble = 1'b1;
            end else if (stall) begin
                ifid_bubble = 1'b0;
                ifid_hold   = 1'b1;
            end else begin
                ifid_bubble = halt_hit;
            end
        end
    end

    always_comb begin
        ifid_d          = '0;
        ifid_d.valid    = 1'b1;
        ifid_d.pc       = pc;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.instr    = imem_rdata;
    end

    if_id_reg #(
        .BUBBLE_INSTR (NOP_WORD)
    ) u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign if_id_valid    = ifid_q.valid;
    assign if_id_pc       = ifid_q.pc;
    assign if_id_pc_plus4 = ifid_q.pc_plus4;
    assign if_id_instr    = ifid_q.instr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            state       <= RUN;
            drain_cnt   <= 8'd0;
            end_program <= 1'b0;
            cycle_count <= 32'd0;
        end else begin
            if (!end_program && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            case (state)
                RUN: begin
                    if (flush) begin
                        pc <= target_aligned;
                    end else if (!stall) begin
                        if (halt_hit) begin
                            drain_cnt <= DRAIN_INIT;
                            state     <= DRAIN;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                DRAIN: begin
                    // A flush here means an older branch made the halt wrong-path.
                    if (flush) begin
                        pc        <= target_aligned;
                        drain_cnt <= 8'd0;
                        state     <= RUN;
                    end else if (!stall) begin
                        drain_cnt <= drain_cnt - 8'd1;
                        if (drain_cnt == 8'd1) begin
                            state       <= DONE;
                            end_program <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    end_program <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end
endmodule
